// File: rtl/chan_coef_pkg.sv
// Shared types and constants for the FIR coefficient sequencer: FSM states,
// ctrl_reg toggle bit indices and status_out field offsets.
package chan_coef_pkg;

    typedef enum logic [1:0] {INIT, IDLE, PEND, SWAP} state_t;

    localparam int CTRL_WR     = 0;
    localparam int CTRL_COMMIT = 1;
    localparam int CTRL_CLEAR  = 2;

    localparam int STAT_PENDING = 0;
    localparam int STAT_BANK    = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_BUSY    = 3;
    localparam int STAT_WRCNT   = 8;
    localparam int STAT_CSUM    = 16;

endpackage

// File: rtl/fir_coef_sequencer_if.sv
// Coefficient RAM write port driven by the sequencer into the FIR coefficient RAM.
interface fir_coef_sequencer_if #(parameter int ADDR_W = 3);

    logic              cw_en;
    logic [ADDR_W-1:0] cw_addr;
    logic [31:0]       cw_data;
    logic              cw_bank;

    modport master (output cw_en, output cw_addr, output cw_data, output cw_bank);
    modport slave  (input  cw_en, input  cw_addr, input  cw_data, input  cw_bank);

endinterface

// File: rtl/chan_toggle_detect.sv
// Turns software toggle bits into one-cycle event pulses; while init is high the
// shadow is loaded silently so stale register contents fire nothing.
module chan_toggle_detect #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         init,
    input  logic [W-1:0] din,
    output logic [W-1:0] evt
);

    logic [W-1:0] shadow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            evt    <= '0;
        end else begin
            shadow <= din;
            evt    <= init ? '0 : (din ^ shadow);
        end
    end

endmodule

// File: rtl/fir_coef_sequencer.sv
// Double-buffered FIR coefficient loader: writes pairs into the inactive bank and
// swaps banks only on sync_in. Define CHAN_COEF_CHECKSUM_EN for the status checksum.
module fir_coef_sequencer
    import chan_coef_pkg::*;
#(
    parameter int NUM_PAIRS = 8,
    parameter int ADDR_W    = 3
) (
    input  logic                  user_clk,
    input  logic                  user_rst_n,
    input  logic [31:0]           coef_reg,
    input  logic [31:0]           ctrl_reg,
    input  logic                  sync_in,
    fir_coef_sequencer_if.master  cw,
    output logic                  bank_sel,
    output logic [31:0]           status_out
);

    localparam logic [ADDR_W:0] LAST    = (ADDR_W+1)'(NUM_PAIRS);
    localparam logic [7:0]      CNT_MAX = 8'(NUM_PAIRS);

    state_t            state, state_d;
    logic [2:0]        evt;
    logic [31:0]       coef_q;
    logic [ADDR_W:0]   wr_addr, wr_addr_d, wr_slot;
    logic [7:0]        wr_count, wr_count_d;
    logic              err_ovf, err_ovf_d, err_busy, err_busy_d, bank_d;
    logic              we_d, clr_ev, idle_now, pend_now, cs_clr;
    logic              en_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q, status_d;
    logic [15:0]       csum;
    logic              ctrl_unused;

    assign ctrl_unused = ^ctrl_reg[31:3];

    chan_toggle_detect #(.W(3)) u_tog (
        .clk   (user_clk),
        .rst_n (user_rst_n),
        .init  (state == INIT),
        .din   (ctrl_reg[2:0]),
        .evt   (evt)
    );

    // Events resolve in order clear, wr, commit: a clear out of PEND lets the
    // same-cycle wr/commit act as if the block were already idle.
    assign clr_ev   = (state != INIT) && evt[CTRL_CLEAR];
    assign idle_now = (state == IDLE) || ((state == PEND) && clr_ev);
    assign pend_now = (state == PEND) && !clr_ev;
    assign cs_clr   = (state == SWAP) || clr_ev;
    assign wr_slot  = clr_ev ? '0 : wr_addr;

    always_comb begin
        state_d    = state;
        wr_addr_d  = wr_addr;
        wr_count_d = wr_count;
        err_ovf_d  = err_ovf;
        err_busy_d = err_busy;
        bank_d     = bank_sel;
        we_d       = 1'b0;
        if (state == INIT) state_d = IDLE;
        if (state == SWAP) begin
            bank_d     = ~bank_sel;
            wr_addr_d  = '0;
            wr_count_d = '0;
            state_d    = IDLE;
        end
        if (clr_ev) begin
            wr_addr_d  = '0;
            wr_count_d = '0;
            err_ovf_d  = 1'b0;
            err_busy_d = 1'b0;
            if (state == PEND) state_d = IDLE;
        end
        if (evt[CTRL_WR]) begin
            if (idle_now) begin
                if (wr_slot < LAST) begin
                    we_d      = 1'b1;
                    wr_addr_d = wr_slot + 1'b1;
                    if (wr_count_d != CNT_MAX) wr_count_d = wr_count_d + 1'b1;
                end else begin
                    err_ovf_d = 1'b1;
                end
            end else if (pend_now) begin
                err_busy_d = 1'b1;
            end
        end
        if (evt[CTRL_COMMIT] && idle_now) state_d = PEND;
        if (pend_now && sync_in) state_d = SWAP;
    end

    always_comb begin
        status_d                   = '0;
        status_d[STAT_PENDING]     = (state == PEND);
        status_d[STAT_BANK]        = bank_sel;
        status_d[STAT_OVF]         = err_ovf;
        status_d[STAT_BUSY]        = err_busy;
        status_d[STAT_WRCNT +: 8]  = wr_count;
        status_d[STAT_CSUM +: 16]  = csum;
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state      <= INIT;
            coef_q     <= '0;
            wr_addr    <= '0;
            wr_count   <= '0;
            err_ovf    <= 1'b0;
            err_busy   <= 1'b0;
            bank_sel   <= 1'b0;
            en_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            status_out <= '0;
        end else begin
            state      <= state_d;
            coef_q     <= coef_reg;
            wr_addr    <= wr_addr_d;
            wr_count   <= wr_count_d;
            err_ovf    <= err_ovf_d;
            err_busy   <= err_busy_d;
            bank_sel   <= bank_d;
            en_q       <= we_d;
            status_out <= status_d;
            if (we_d) begin
                addr_q <= wr_slot[ADDR_W-1:0];
                data_q <= coef_q;
            end
        end
    end

`ifdef CHAN_COEF_CHECKSUM_EN
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n)  csum <= '0;
        else if (we_d)    csum <= (cs_clr ? 16'h0 : csum) + coef_q[31:16] + coef_q[15:0];
        else if (cs_clr)  csum <= '0;
    end
`else
    logic cs_unused;
    assign cs_unused = cs_clr;
    assign csum      = '0;
`endif

    assign cw.cw_en   = en_q;
    assign cw.cw_addr = addr_q;
    assign cw.cw_data = data_q;
    assign cw.cw_bank = ~bank_sel;

endmodule
